// File: rtl/uart_apb_ctrl_pkg.sv
// Shared definitions for the APB master that drives a CoreUARTapb:
// register map, STATUS bit positions, FSM encodings, CTRL2 packing.
package uart_apb_ctrl_pkg;

  localparam logic [4:0] A_TXDATA = 5'h00;
  localparam logic [4:0] A_RXDATA = 5'h04;
  localparam logic [4:0] A_CTRL1  = 5'h08;
  localparam logic [4:0] A_CTRL2  = 5'h0C;
  localparam logic [4:0] A_STATUS = 5'h10;

  localparam int B_TXRDY  = 0;
  localparam int B_RXRDY  = 1;
  localparam int B_PARITY = 2;
  localparam int B_OVFL   = 3;
  localparam int B_FRAME  = 4;

  typedef enum logic [2:0] {
    S_CFG1,
    S_CFG2,
    S_STAT,
    S_RXRD,
    S_TXWR
  } state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SETUP,
    P_ACCESS
  } phase_t;

  typedef enum logic {
    G_RX = 1'b0,
    G_TX = 1'b1
  } grant_t;

  typedef struct packed {
    logic [4:0] addr;
    logic       write;
    logic [7:0] wdata;
  } req_t;

  function automatic logic [7:0] ctrl2_pack(
    input logic [4:0] baud_hi,
    input logic       bit8,
    input logic       parity,
    input logic       odd
  );
    return {baud_hi, odd, parity, bit8};
  endfunction

endpackage

// File: rtl/uart_apb_ctrl_xfer.sv
// Single-transaction APB engine; a new request is accepted on the
// completing edge so back-to-back transfers have no idle cycle.
module uart_apb_ctrl_xfer
  import uart_apb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] addr,
  input  logic       write,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       slverr,
  output logic [4:0] paddr,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  phase_t phase;
  logic   take;

  assign done   = (phase == P_ACCESS) && pready;
  assign rdata  = prdata;
  assign slverr = pslverr;
  assign take   = start && ((phase == P_IDLE) || done);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase   <= P_IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
    end else if (take) begin
      phase   <= P_SETUP;
      psel    <= 1'b1;
      penable <= 1'b0;
      paddr   <= addr;
      pwrite  <= write;
      pwdata  <= wdata;
    end else if (phase == P_SETUP) begin
      phase   <= P_ACCESS;
      penable <= 1'b1;
    end else if (done) begin
      phase   <= P_IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB master turning a CoreUARTapb into RX/TX byte streams.
// Optional err_count output: define UART_APB_CTRL_ERRCNT_EN.
module uart_apb_ctrl
  import uart_apb_ctrl_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic        PRG_BIT8   = 1'b0,
  parameter logic        PRG_PARITY = 1'b0,
  parameter logic        ODD_N_EVEN = 1'b0
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  output logic [4:0] M_PADDR,
  output logic       M_PSEL,
  output logic       M_PENABLE,
  output logic       M_PWRITE,
  output logic [7:0] M_PWDATA,
  input  logic [7:0] M_PRDATA,
  input  logic       M_PREADY,
  input  logic       M_PSLVERR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       cfg_done,
  output logic       err_parity,
  output logic       err_overflow,
  output logic       err_framing,
  output logic       err_slverr,
  input  logic       err_clr
`ifdef UART_APB_CTRL_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  state_t     state;
  state_t     nxt;
  grant_t     last_grant;
  req_t       req;
  logic       done;
  logic       slverr;
  logic [7:0] rdata;
  logic       stat_done;
  logic       rx_ok;
  logic       tx_ok;
  logic       grant_rx;
  logic       grant_tx;
  logic [2:0] err_set;

  uart_apb_ctrl_xfer u_xfer (
    .clk     (PCLK),
    .rst_n   (PRESETN),
    .start   (1'b1),
    .addr    (req.addr),
    .write   (req.write),
    .wdata   (req.wdata),
    .done    (done),
    .rdata   (rdata),
    .slverr  (slverr),
    .paddr   (M_PADDR),
    .psel    (M_PSEL),
    .penable (M_PENABLE),
    .pwrite  (M_PWRITE),
    .pwdata  (M_PWDATA),
    .prdata  (M_PRDATA),
    .pready  (M_PREADY),
    .pslverr (M_PSLVERR)
  );

  assign stat_done = done && (state == S_STAT);
  assign rx_ok     = rdata[B_RXRDY] && !rx_valid;
  assign tx_ok     = rdata[B_TXRDY] && tx_valid;
  assign err_set   = stat_done ? rdata[B_FRAME:B_PARITY] : 3'b000;

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state      <= S_CFG1;
      last_grant <= G_TX;
    end else begin
      state <= nxt;
      if (grant_rx) last_grant <= G_RX;
      else if (grant_tx) last_grant <= G_TX;
    end
  end

  // req describes the transfer loaded on this edge: the one after
  // a completion, or the pending one while the engine is idle.
  always_comb begin
    nxt      = state;
    grant_rx = 1'b0;
    grant_tx = 1'b0;
    req      = '0;
    if (stat_done) begin
      grant_rx = rx_ok && (!tx_ok || last_grant == G_TX);
      grant_tx = tx_ok && !grant_rx;
    end
    if (done) begin
      unique case (state)
        S_CFG1:  nxt = S_CFG2;
        S_CFG2:  nxt = S_STAT;
        S_STAT:  nxt = grant_rx ? S_RXRD :
                       grant_tx ? S_TXWR : S_STAT;
        default: nxt = S_STAT;
      endcase
    end
    unique case (1'b1)
      nxt == S_CFG1:
        req = '{A_CTRL1, 1'b1, BAUD_VALUE[7:0]};
      nxt == S_CFG2:
        req = '{A_CTRL2, 1'b1,
                ctrl2_pack(BAUD_VALUE[12:8], PRG_BIT8,
                           PRG_PARITY, ODD_N_EVEN)};
      nxt == S_RXRD:
        req = '{A_RXDATA, 1'b0, 8'h00};
      nxt == S_TXWR:
        req = '{A_TXDATA, 1'b1, tx_data};
      default:
        req = '{A_STATUS, 1'b0, 8'h00};
    endcase
  end

  assign tx_ready = grant_tx;

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      if (done && state == S_RXRD && !slverr) begin
        rx_data  <= rdata;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (done && state == S_CFG2) cfg_done <= 1'b1;
    end
  end

  // A new error in the clearing cycle survives the clear.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      err_parity   <= 1'b0;
      err_overflow <= 1'b0;
      err_framing  <= 1'b0;
      err_slverr   <= 1'b0;
    end else begin
      err_parity   <= err_set[0] | (err_parity & !err_clr);
      err_overflow <= err_set[1] | (err_overflow & !err_clr);
      err_framing  <= err_set[2] | (err_framing & !err_clr);
      err_slverr   <= (done & slverr) | (err_slverr & !err_clr);
    end
  end

`ifdef UART_APB_CTRL_ERRCNT_EN
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      err_count <= '0;
    end else if (|err_set) begin
      if (err_clr) err_count <= 8'd1;
      else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end else if (err_clr) begin
      err_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Self-checking bench for uart_apb_ctrl: vector table, corner-case
// sequences and a randomized run against a poll-level reference model.
module tb_uart_apb_ctrl;

  localparam logic [12:0] BAUD = 13'h123;
  localparam logic BIT8 = 1'b1;
  localparam logic PAR  = 1'b0;
  localparam logic ODD  = 1'b0;
  localparam logic [4:0] A_TX = 5'h00;
  localparam logic [4:0] A_RX = 5'h04;
  localparam logic [4:0] A_C1 = 5'h08;
  localparam logic [4:0] A_C2 = 5'h0C;
  localparam logic [4:0] A_ST = 5'h10;
  localparam logic [7:0] EXP_C1 = 8'(BAUD % 256);
  localparam logic [7:0] EXP_C2 =
    8'((BAUD / 256) * 8 + ODD * 4 + PAR * 2 + BIT8);

  logic       PCLK = 1'b0;
  logic       PRESETN = 1'b0;
  logic [4:0] M_PADDR;
  logic       M_PSEL, M_PENABLE, M_PWRITE;
  logic [7:0] M_PWDATA;
  logic [7:0] M_PRDATA;
  logic       M_PREADY = 1'b1;
  logic       M_PSLVERR = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       cfg_done;
  logic       err_parity, err_overflow, err_framing, err_slverr;
  logic       err_clr = 1'b0;
`ifdef UART_APB_CTRL_ERRCNT_EN
  logic [7:0] err_count;
`endif

  logic [7:0] status = 8'h00;
  logic [7:0] rxbyte = 8'h00;

  int n_pass = 0;
  int n_total = 0;

  uart_apb_ctrl #(
    .BAUD_VALUE (BAUD),
    .PRG_BIT8   (BIT8),
    .PRG_PARITY (PAR),
    .ODD_N_EVEN (ODD)
  ) dut (
    .PCLK         (PCLK),
    .PRESETN      (PRESETN),
    .M_PADDR      (M_PADDR),
    .M_PSEL       (M_PSEL),
    .M_PENABLE    (M_PENABLE),
    .M_PWRITE     (M_PWRITE),
    .M_PWDATA     (M_PWDATA),
    .M_PRDATA     (M_PRDATA),
    .M_PREADY     (M_PREADY),
    .M_PSLVERR    (M_PSLVERR),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .cfg_done     (cfg_done),
    .err_parity   (err_parity),
    .err_overflow (err_overflow),
    .err_framing  (err_framing),
    .err_slverr   (err_slverr),
    .err_clr      (err_clr)
`ifdef UART_APB_CTRL_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 PCLK = ~PCLK;

  // UART register file stand-in: STATUS and RXDATA reads.
  assign M_PRDATA = (M_PADDR == A_ST) ? status :
                    (M_PADDR == A_RX) ? rxbyte : 8'h00;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] bus();
    return {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA};
  endfunction

  function automatic logic [3:0] flags();
    return {err_slverr, err_framing, err_overflow, err_parity};
  endfunction

  // Waits for a STATUS setup, presents one status/tx/rx scenario,
  // and returns at the setup of the following transaction.
  task automatic poll(input logic [7:0] st, input logic txv,
                      input logic [7:0] txd, input logic rr,
                      input logic ec, input logic [7:0] rb,
                      output logic rv0, output logic [7:0] rd0,
                      output logic [4:0] ad, output logic wr,
                      output logic [7:0] wd, output logic txr);
    int n;
    logic ok;
    n = 0;
    while (!(M_PSEL && !M_PENABLE && M_PADDR == A_ST) && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    ok = M_PSEL && !M_PENABLE && M_PADDR == A_ST;
    if (!ok) begin
      n_total++;
      $display("FAIL poll_timeout: paddr=%0h, required STATUS setup", M_PADDR);
      return;
    end
    rv0 = rx_valid;
    rd0 = rx_data;
    status = st;
    tx_valid = txv;
    tx_data = txd;
    rx_ready = rr;
    rxbyte = rb;
    @(negedge PCLK);
    txr = tx_ready;
    err_clr = ec;
    @(negedge PCLK);
    err_clr = 1'b0;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    status = 8'h00;
    ad = M_PADDR;
    wr = M_PWRITE;
    wd = M_PWDATA;
  endtask

  task automatic config_check();
    check("cfg_done_in_reset", 32'(cfg_done), 0);
    PRESETN = 1'b1;
    @(negedge PCLK);
    check("cfg1_setup", 32'(bus()), 32'({3'b101, A_C1, EXP_C1}));
    @(negedge PCLK);
    check("cfg1_access", 32'(bus()), 32'({3'b111, A_C1, EXP_C1}));
    @(negedge PCLK);
    check("cfg2_setup", 32'(bus()), 32'({3'b101, A_C2, EXP_C2}));
    @(negedge PCLK);
    check("cfg2_access", 32'(bus()), 32'({3'b111, A_C2, EXP_C2}));
    check("cfg_done_cyc3", 32'(cfg_done), 0);
    @(negedge PCLK);
    check("cfg_done_cyc4", 32'(cfg_done), 1);
    check("first_stat", 32'({M_PSEL, M_PENABLE, M_PWRITE, M_PADDR}),
          32'({3'b100, A_ST}));
  endtask

  typedef struct {
    logic [7:0] st;
    logic       txv;
    logic [7:0] txd;
    logic [4:0] exp_addr;
    logic       exp_txr;
  } vec_t;

  vec_t vecs[8];

  logic       rv0, wr, txr;
  logic [7:0] rd0, wd;
  logic [4:0] ad;

  logic       m_last_tx, m_rv, rv_g, rxo, txo;
  logic [7:0] m_rxd;
  logic [3:0] m_flags;
  int         m_cnt, g;
  logic [7:0] r_st, r_txd, r_rb;
  logic       r_txv, r_rr, r_ec;
  logic [4:0] addr_of[3];

  initial begin
    vecs[0] = '{8'h01, 1'b1, 8'hA5, A_TX, 1'b1};
    vecs[1] = '{8'h03, 1'b1, 8'h11, A_RX, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 8'h22, A_TX, 1'b1};
    vecs[3] = '{8'h03, 1'b1, 8'h33, A_RX, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 8'h44, A_ST, 1'b0};
    vecs[5] = '{8'h01, 1'b0, 8'h55, A_ST, 1'b0};
    vecs[6] = '{8'h02, 1'b0, 8'h66, A_RX, 1'b0};
    vecs[7] = '{8'h01, 1'b1, 8'h7E, A_TX, 1'b1};
    addr_of = '{A_ST, A_RX, A_TX};

    repeat (3) @(negedge PCLK);
    check("rst_bus", 32'(bus()), 0);
    check("rst_hs", 32'({tx_ready, rx_valid, cfg_done}), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_flags", 32'(flags()), 0);
`ifdef UART_APB_CTRL_ERRCNT_EN
    check("rst_err_count", 32'(err_count), 0);
`endif
    config_check();

    for (int i = 0; i < 8; i++) begin
      poll(vecs[i].st, vecs[i].txv, vecs[i].txd, 1'b1, 1'b0, 8'h5A,
           rv0, rd0, ad, wr, wd, txr);
      check($sformatf("vec%0d_addr", i), 32'(ad), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_tx_ready", i), 32'(txr), 32'(vecs[i].exp_txr));
      check($sformatf("vec%0d_write", i), 32'(wr), 32'(vecs[i].exp_txr));
      if (vecs[i].exp_txr)
        check($sformatf("vec%0d_wdata", i), 32'(wd), 32'(vecs[i].txd));
    end
    check("rx_data_after_table", 32'(rx_data), 32'h5A);

    // rx_valid held: no RXDATA reads until the consumer takes the byte
    poll(8'h02, 0, 0, 0, 0, 8'h66, rv0, rd0, ad, wr, wd, txr);
    check("hold_first_rd", 32'(ad), 32'(A_RX));
    for (int i = 0; i < 3; i++) begin
      poll(8'h02, 0, 0, 0, 0, 8'hC3, rv0, rd0, ad, wr, wd, txr);
      check($sformatf("hold%0d_no_rd", i), 32'(ad), 32'(A_ST));
      check($sformatf("hold%0d_rx", i), 32'({rv0, rd0}), 32'({1'b1, 8'h66}));
    end
    poll(8'h02, 0, 0, 1, 0, 8'hC3, rv0, rd0, ad, wr, wd, txr);
    check("hold_release_rd", 32'(ad), 32'(A_RX));
    poll(8'h00, 0, 0, 1, 0, 8'h00, rv0, rd0, ad, wr, wd, txr);
    check("hold_new_byte", 32'({rv0, rd0}), 32'({1'b1, 8'hC3}));

    // sticky errors, clear priority, counter
    poll(8'h1C, 0, 0, 0, 0, 0, rv0, rd0, ad, wr, wd, txr);
    check("err_all_set", 32'(flags()), 32'h7);
`ifdef UART_APB_CTRL_ERRCNT_EN
    check("err_count_1", 32'(err_count), 1);
`endif
    poll(8'h04, 0, 0, 0, 0, 0, rv0, rd0, ad, wr, wd, txr);
`ifdef UART_APB_CTRL_ERRCNT_EN
    check("err_count_2", 32'(err_count), 2);
`endif
    poll(8'h04, 0, 0, 0, 1, 0, rv0, rd0, ad, wr, wd, txr);
    check("err_set_wins", 32'(flags()), 32'h1);
`ifdef UART_APB_CTRL_ERRCNT_EN
    check("err_count_clr_inc", 32'(err_count), 1);
`endif
    poll(8'h00, 0, 0, 0, 1, 0, rv0, rd0, ad, wr, wd, txr);
    check("err_cleared", 32'(flags()), 0);
    for (int i = 0; i < 300; i++)
      poll(8'h04, 0, 0, 0, 0, 0, rv0, rd0, ad, wr, wd, txr);
    check("err_parity_sat", 32'(flags()), 32'h1);
`ifdef UART_APB_CTRL_ERRCNT_EN
    check("err_count_sat", 32'(err_count), 32'hFF);
`endif

    // PSLVERR on RXDATA read drops the byte
    poll(8'h02, 0, 0, 0, 0, 8'h99, rv0, rd0, ad, wr, wd, txr);
    check("slv_rd_addr", 32'(ad), 32'(A_RX));
    M_PSLVERR = 1'b1;
    repeat (2) @(negedge PCLK);
    M_PSLVERR = 1'b0;
    check("slv_dropped", 32'({rx_valid, rx_data}), 32'({1'b0, 8'hC3}));
    check("slv_flag", 32'(err_slverr), 1);

    // wait states on TXWR, then reset in the middle of ACCESS
    poll(8'h01, 1, 8'h3C, 0, 0, 0, rv0, rd0, ad, wr, wd, txr);
    check("stall_tx_ready", 32'(txr), 1);
    M_PREADY = 1'b0;
    repeat (3) @(negedge PCLK);
    check("stall_access", 32'(bus()), 32'({3'b111, A_TX, 8'h3C}));
    PRESETN = 1'b0;
    @(negedge PCLK);
    check("rst_mid_access", 32'({M_PSEL, M_PENABLE}), 0);
    M_PREADY = 1'b1;
    @(negedge PCLK);
    config_check();

    // randomized polls against a poll-level model
    m_last_tx = 1'b1;
    m_rv = 1'b0;
    m_rxd = 8'h00;
    m_flags = 4'h0;
    m_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      r_st = 8'($urandom_range(0, 31));
      r_txv = 1'($urandom_range(0, 1));
      r_txd = 8'($urandom);
      r_rr = 1'($urandom_range(0, 1));
      r_ec = ($urandom_range(0, 7) == 0);
      r_rb = 8'($urandom);
      poll(r_st, r_txv, r_txd, r_rr, r_ec, r_rb, rv0, rd0, ad, wr, wd, txr);
      check($sformatf("rnd%0d_rx_in", i), 32'({rv0, rd0}), 32'({m_rv, m_rxd}));
      rv_g = m_rv && !r_rr;
      rxo = r_st[1] && !rv_g;
      txo = r_st[0] && r_txv;
      if (rxo && txo) g = m_last_tx ? 1 : 2;
      else if (rxo) g = 1;
      else if (txo) g = 2;
      else g = 0;
      if (g != 0) m_last_tx = (g == 2);
      check($sformatf("rnd%0d_addr", i), 32'(ad), 32'(addr_of[g]));
      check($sformatf("rnd%0d_tx_ready", i), 32'(txr), 32'(g == 2));
      if (g == 2) check($sformatf("rnd%0d_wdata", i), 32'(wd), 32'(r_txd));
      if (g == 1) begin
        m_rv = 1'b1;
        m_rxd = r_rb;
      end else begin
        m_rv = rv_g;
      end
      m_flags[2:0] = r_st[4:2] | (m_flags[2:0] & ~{3{r_ec}});
      m_flags[3] = m_flags[3] & !r_ec;
      if (r_st[4:2] != 0) m_cnt = r_ec ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
      else if (r_ec) m_cnt = 0;
      check($sformatf("rnd%0d_flags", i), 32'(flags()), 32'(m_flags));
`ifdef UART_APB_CTRL_ERRCNT_EN
      check($sformatf("rnd%0d_err_count", i), 32'(err_count), 32'(m_cnt));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
